multicycle_ctrl: RTL and testbench

- Parametrised multicycle control FSM for the MIPS-subset datapath; drives every datapath mux and write-enable from opcode/funct and ALU flags.
- Adds variable-latency memory handshake (mem_ready), BNE support, illegal-opcode detection and a state debug port.
- Sits between instruction register and datapath; one instruction in flight.

---
 rtl/ctrl_pkg.sv | 59 +++++
 rtl/multicycle_ctrl_if.sv | 51 +++++
 rtl/ctrl_decode.sv | 28 ++
 rtl/multicycle_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle MIPS-subset controller.
//   - state_e   : FSM state encoding, also the value presented on state_out
//   - OP_* / FN_* : opcode and R-type funct values the controller recognises
//   - ALU_*     : alu_op codes
//   - SRCB_*    : alu_src_b mux selects
//   - PCSRC_*   : pc_source mux selects
// Optional build macro: CTRL_EXCEPTION_EN adds the EXC state.
package ctrl_pkg;

  localparam int CTRL_STATE_W = 7;

  typedef enum logic [CTRL_STATE_W-1:0] {
    S_RESET     = 7'd0,
    S_FETCH     = 7'd1,
    S_DECODE    = 7'd2,
    S_MEM_ADDR  = 7'd3,
    S_MEM_RD    = 7'd4,
    S_MEM_WB    = 7'd5,
    S_MEM_WR    = 7'd6,
    S_R_EXEC    = 7'd7,
    S_R_WB      = 7'd8,
    S_ADDI_EXEC = 7'd9,
    S_ADDI_WB   = 7'd10,
    S_BRANCH    = 7'd11,
    S_JUMP      = 7'd12
`ifdef CTRL_EXCEPTION_EN
    , S_EXC     = 7'd13
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_SLT   = 3'd4;
  localparam logic [2:0] ALU_FUNCT = 3'd7;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_EXC    = 2'd3;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: bundle between the controller and the datapath.
//   Inputs to controller : opcode, funct, zero, overflow, mem_ready
//   Outputs of controller: PC/memory/IR/regfile enables, mux selects,
//                          alu_op, epc_write, exception, state_out
// Memory handshake: mem_read / mem_write is a request that stays high until
// the memory raises mem_ready in the same cycle; the access completes on the
// clock edge where request && mem_ready. Only one request is ever active.
// modport master = controller side, modport slave = datapath side.
interface multicycle_ctrl_if #(
  parameter int OPCODE_W = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALUOP_W  = 3,
  parameter int STATE_W  = 7
);
  logic [OPCODE_W-1:0] opcode;
  logic [FUNCT_W-1:0]  funct;
  logic                zero;
  logic                overflow;
  logic                mem_ready;

  logic                pc_write;
  logic                pc_write_cond;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALUOP_W-1:0]  alu_op;
  logic [1:0]          pc_source;
  logic                epc_write;
  logic                exception;
  logic [STATE_W-1:0]  state_out;

  modport master (
    input  opcode, funct, zero, overflow, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, epc_write, exception, state_out
  );

  modport slave (
    output opcode, funct, zero, overflow, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, epc_write, exception, state_out
  );
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode dispatch used in the DECODE state.
//   opcode   in  : IR[31:26]
//   dispatch out : state to enter after DECODE for a recognised opcode
//   illegal  out : opcode not recognised (dispatch is FETCH in that case)
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output state_e              dispatch,
  output logic                illegal
);

  always_comb begin
    dispatch = S_FETCH;
    illegal  = 1'b0;
    case (opcode)
      OPCODE_W'(OP_RTYPE):                dispatch = S_R_EXEC;
      OPCODE_W'(OP_LW), OPCODE_W'(OP_SW): dispatch = S_MEM_ADDR;
      OPCODE_W'(OP_BEQ), OPCODE_W'(OP_BNE): dispatch = S_BRANCH;
      OPCODE_W'(OP_J):                    dispatch = S_JUMP;
      OPCODE_W'(OP_ADDI):                 dispatch = S_ADDI_EXEC;
      default:                            illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle control FSM for the MIPS-subset datapath.
//   clock, reset (asynchronous, active-high)
//   bus (multicycle_ctrl_if.master): opcode/funct/zero/overflow/mem_ready in;
//       every datapath enable and mux select out, plus state_out for debug.
// All outputs are decoded combinationally from the current state (FETCH also
// looks at mem_ready, BRANCH at zero), so async reset zeroes them at once.
// Optional build macro: CTRL_EXCEPTION_EN (illegal opcode / arithmetic
// overflow trap into EXC; without it illegal opcodes behave as NOPs).
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALUOP_W  = 3,
  parameter int STATE_W  = 7
) (
  input logic               clock,
  input logic               reset,
  multicycle_ctrl_if.master bus
);

  state_e state, state_next, dispatch;
  logic   illegal;
  logic   take_branch;
  logic   arith_trap;

  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, epc_write, exception;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;

  ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode   (bus.opcode),
    .dispatch (dispatch),
    .illegal  (illegal)
  );

  // Branch condition is resolved here so the datapath sees one PC enable.
  assign take_branch = ((bus.opcode == OPCODE_W'(OP_BEQ)) &&  bus.zero) ||
                       ((bus.opcode == OPCODE_W'(OP_BNE)) && !bus.zero);

`ifdef CTRL_EXCEPTION_EN
  // Only signed add/sub R-types and ADDI trap on overflow; addu-style
  // functs and logic ops ignore the flag.
  assign arith_trap = bus.overflow &&
                      ((bus.opcode == OPCODE_W'(OP_ADDI)) ||
                       (bus.funct == FUNCT_W'(FN_ADD)) ||
                       (bus.funct == FUNCT_W'(FN_SUB)));
`else
  logic [FUNCT_W:0] unused_inputs;
  assign unused_inputs = {bus.funct, bus.overflow};
  assign arith_trap    = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_RESET;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    epc_write     = 1'b0;
    exception     = 1'b0;
    case (state)
      S_RESET: state_next = S_FETCH;
      S_FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          ir_write   = 1'b1;
          alu_src_b  = SRCB_FOUR;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b = SRCB_IMM_SH;
`ifdef CTRL_EXCEPTION_EN
        state_next = illegal ? S_EXC : dispatch;
`else
        state_next = illegal ? S_FETCH : dispatch;
`endif
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = (bus.opcode == OPCODE_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        if (bus.mem_ready) state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) state_next = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
`ifdef CTRL_EXCEPTION_EN
        state_next = arith_trap ? S_EXC : S_R_WB;
`else
        state_next = S_R_WB;
`endif
      end
      S_R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
`ifdef CTRL_EXCEPTION_EN
        state_next = arith_trap ? S_EXC : S_ADDI_WB;
`else
        state_next = S_ADDI_WB;
`endif
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_source     = PCSRC_ALUOUT;
        pc_write_cond = take_branch;
        state_next    = S_FETCH;
      end
      S_JUMP: begin
        pc_source  = PCSRC_JUMP;
        pc_write   = 1'b1;
        state_next = S_FETCH;
      end
`ifdef CTRL_EXCEPTION_EN
      S_EXC: begin
        epc_write  = 1'b1;
        exception  = 1'b1;
        pc_source  = PCSRC_EXC;
        pc_write   = 1'b1;
        state_next = S_FETCH;
      end
`endif
      default: state_next = S_RESET;
    endcase
  end

  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.i_or_d        = i_or_d;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.ir_write      = ir_write;
  assign bus.reg_dst       = reg_dst;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.reg_write     = reg_write;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_op        = ALUOP_W'(alu_op);
  assign bus.pc_source     = pc_source;
  assign bus.epc_write     = epc_write;
  assign bus.exception     = exception;
  assign bus.state_out     = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam int OPCODE_W = 6;
  localparam int FUNCT_W  = 6;
  localparam int ALUOP_W  = 3;
  localparam int STATE_W  = 7;
`ifdef CTRL_EXCEPTION_EN
  localparam bit               EXC_EN   = 1'b1;
  localparam logic [STATE_W-1:0] EXC_CODE = S_EXC;
`else
  localparam bit               EXC_EN   = 1'b0;
  localparam logic [STATE_W-1:0] EXC_CODE = 7'h7F;
`endif

  typedef struct packed {
    logic [STATE_W-1:0] st;
    logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic epc_write, exception;
  } obs_t;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  multicycle_ctrl_if #(.OPCODE_W(OPCODE_W), .FUNCT_W(FUNCT_W),
                       .ALUOP_W(ALUOP_W), .STATE_W(STATE_W)) bus ();

  multicycle_ctrl #(.OPCODE_W(OPCODE_W), .FUNCT_W(FUNCT_W),
                    .ALUOP_W(ALUOP_W), .STATE_W(STATE_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  obs_t tr[$];
  logic [STATE_W-1:0] exp_q[$];
  bit timed_out;

  // expectations from the reference model
  int exp_rd, exp_wr, exp_rw, exp_pcw, exp_pcc, exp_exc;
  // tallies from the recorded trace
  int act_rd, act_wr, act_ir, act_rw, act_pcw, act_pcc, act_epc, act_excp, act_both;

  function automatic obs_t sample();
    obs_t o;
    o.st = bus.state_out;
    o.pc_write = bus.pc_write; o.pc_write_cond = bus.pc_write_cond;
    o.i_or_d = bus.i_or_d; o.mem_read = bus.mem_read; o.mem_write = bus.mem_write;
    o.ir_write = bus.ir_write; o.reg_dst = bus.reg_dst; o.mem_to_reg = bus.mem_to_reg;
    o.reg_write = bus.reg_write; o.alu_src_a = bus.alu_src_a; o.alu_src_b = bus.alu_src_b;
    o.alu_op = bus.alu_op; o.pc_source = bus.pc_source;
    o.epc_write = bus.epc_write; o.exception = bus.exception;
    return o;
  endfunction

  function automatic obs_t outputs_only();
    obs_t o;
    o = sample();
    o.st = '0;
    return o;
  endfunction

  function automatic int find_state(input logic [STATE_W-1:0] s);
    foreach (tr[i]) if (tr[i].st == s) return i;
    return -1;
  endfunction

  function automatic obs_t at_state(input logic [STATE_W-1:0] s);
    int idx;
    obs_t z;
    z = '0;
    idx = find_state(s);
    return (idx >= 0) ? tr[idx] : z;
  endfunction

  // ---------------- driver ----------------
  // Starts at a falling edge with the DUT in FETCH, runs one instruction and
  // records one sample per cycle until FETCH is re-entered. Memory answers
  // the instruction fetch after fl wait cycles and the data access after ml.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic ov, input int fl, input int ml);
    int phase, wait_cnt, lat;
    logic req;
    logic [STATE_W-1:0] prev;
    tr.delete();
    bus.opcode = op; bus.funct = fn; bus.zero = z; bus.overflow = ov;
    phase = 0; wait_cnt = 0; timed_out = 1'b1;
    for (int cyc = 0; cyc < 64; cyc++) begin
      req = bus.mem_read | bus.mem_write;
      lat = (phase == 0) ? fl : ml;
      bus.mem_ready = req && (wait_cnt == lat);
      #1;
      tr.push_back(sample());
      if (req && bus.mem_ready) begin phase++; wait_cnt = 0; end
      else if (req) wait_cnt++;
      prev = bus.state_out;
      @(posedge clock); @(negedge clock);
      if (bus.state_out == S_FETCH && prev != S_FETCH) begin
        timed_out = 1'b0;
        break;
      end
    end
    bus.mem_ready = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Instruction-level view: which phases an instruction visits and how many
  // times each control event should fire, given the memory latencies.
  task automatic build_expected(input logic [5:0] op, input logic [5:0] fn,
                                input logic z, input logic ov, input int fl, input int ml);
    bit legal, trap;
    exp_q.delete();
    legal = (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) ||
            (op == 6'h05) || (op == 6'h02) || (op == 6'h08);
    trap  = ov && ((op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) || op == 6'h08);
    exp_exc = (EXC_EN && (!legal || trap)) ? 1 : 0;
    for (int i = 0; i <= fl; i++) exp_q.push_back(S_FETCH);
    exp_q.push_back(S_DECODE);
    exp_rd = fl + 1; exp_wr = 0; exp_rw = 0; exp_pcc = 0;
    case (op)
      6'h00: begin
        exp_q.push_back(S_R_EXEC);
        if (exp_exc != 0) exp_q.push_back(EXC_CODE);
        else begin exp_q.push_back(S_R_WB); exp_rw = 1; end
      end
      6'h08: begin
        exp_q.push_back(S_ADDI_EXEC);
        if (exp_exc != 0) exp_q.push_back(EXC_CODE);
        else begin exp_q.push_back(S_ADDI_WB); exp_rw = 1; end
      end
      6'h23: begin
        exp_q.push_back(S_MEM_ADDR);
        for (int i = 0; i <= ml; i++) exp_q.push_back(S_MEM_RD);
        exp_q.push_back(S_MEM_WB);
        exp_rd += ml + 1; exp_rw = 1;
      end
      6'h2B: begin
        exp_q.push_back(S_MEM_ADDR);
        for (int i = 0; i <= ml; i++) exp_q.push_back(S_MEM_WR);
        exp_wr = ml + 1;
      end
      6'h04: begin exp_q.push_back(S_BRANCH); exp_pcc = z ? 1 : 0; end
      6'h05: begin exp_q.push_back(S_BRANCH); exp_pcc = z ? 0 : 1; end
      6'h02: exp_q.push_back(S_JUMP);
      default: if (exp_exc != 0) exp_q.push_back(EXC_CODE);
    endcase
    exp_pcw = 1 + ((op == 6'h02) ? 1 : 0) + exp_exc;
  endtask

  task automatic tally();
    act_rd = 0; act_wr = 0; act_ir = 0; act_rw = 0; act_pcw = 0;
    act_pcc = 0; act_epc = 0; act_excp = 0; act_both = 0;
    foreach (tr[i]) begin
      act_rd   += int'(tr[i].mem_read);
      act_wr   += int'(tr[i].mem_write);
      act_ir   += int'(tr[i].ir_write);
      act_rw   += int'(tr[i].reg_write);
      act_pcw  += int'(tr[i].pc_write);
      act_pcc  += int'(tr[i].pc_write_cond);
      act_epc  += int'(tr[i].epc_write);
      act_excp += int'(tr[i].exception);
      act_both += int'(tr[i].mem_read & tr[i].mem_write);
    end
  endtask

  function automatic int path_mismatch();
    if (tr.size() != exp_q.size()) return 0;
    foreach (tr[i]) if (tr[i].st != exp_q[i]) return i + 1;
    return -1;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    obs_t o;
    reset = 1'b1;
    bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.overflow = 1'b0; bus.mem_ready = 1'b0;
    #3;
    tests_run++;
    if (bus.state_out !== S_RESET || outputs_only() !== '0) begin
      tests_failed++;
      $display("FAIL reset_init: state=%0d outs=%h, expected state=%0d outs=0", bus.state_out, outputs_only(), S_RESET);
    end
    @(negedge clock); reset = 1'b0;
    @(posedge clock); @(negedge clock);
    tests_run++;
    if (bus.state_out !== S_FETCH) begin
      tests_failed++;
      $display("FAIL reset_to_fetch: state=%0d expected %0d", bus.state_out, S_FETCH);
    end
    // walk a load into MEM_RD with memory stalled, then reset mid-access
    bus.opcode = 6'h23; bus.mem_ready = 1'b1;
    @(posedge clock); @(negedge clock); bus.mem_ready = 1'b0;
    @(posedge clock); @(negedge clock);
    @(posedge clock); @(negedge clock);
    tests_run++;
    if (bus.state_out !== S_MEM_RD || bus.mem_read !== 1'b1) begin
      tests_failed++;
      $display("FAIL reach_mem_rd: state=%0d mem_read=%b expected %0d/1", bus.state_out, bus.mem_read, S_MEM_RD);
    end
    #2 reset = 1'b1;
    #1;
    o = outputs_only();
    tests_run++;
    if (bus.state_out !== S_RESET || o !== '0) begin
      tests_failed++;
      $display("FAIL reset_async: state=%0d outs=%h expected %0d/0", bus.state_out, o, S_RESET);
    end
    @(posedge clock); @(negedge clock);
    tests_run++;
    if (bus.state_out !== S_RESET || outputs_only() !== '0) begin
      tests_failed++;
      $display("FAIL reset_held: state=%0d outs=%h expected %0d/0", bus.state_out, outputs_only(), S_RESET);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus.state_out !== S_RESET) begin
      tests_failed++;
      $display("FAIL reset_release: state=%0d expected %0d", bus.state_out, S_RESET);
    end
    @(posedge clock); @(negedge clock);
    tests_run++;
    if (bus.state_out !== S_FETCH || bus.mem_read !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_refetch: state=%0d mem_read=%b expected %0d/1", bus.state_out, bus.mem_read, S_FETCH);
    end
  endtask

  task automatic test_lw();
    int n_fetch_rd, n_mem_rd, n_iord;
    obs_t wb;
    run_instr(6'h23, 6'h00, 1'b0, 1'b0, 3, 3);
    build_expected(6'h23, 6'h00, 1'b0, 1'b0, 3, 3);
    tally();
    n_fetch_rd = 0; n_mem_rd = 0; n_iord = 0;
    foreach (tr[i]) begin
      if (tr[i].st == S_FETCH && tr[i].mem_read) n_fetch_rd++;
      if (tr[i].st == S_MEM_RD && tr[i].mem_read) n_mem_rd++;
      if (tr[i].st == S_MEM_RD && tr[i].i_or_d) n_iord++;
    end
    tests_run++;
    if (timed_out || path_mismatch() != -1) begin
      tests_failed++;
      $display("FAIL lw_path: cycles=%0d mismatch_at=%0d expected cycles=%0d", tr.size(), path_mismatch(), exp_q.size());
    end
    tests_run++;
    if (n_fetch_rd != 4 || n_mem_rd != 4) begin
      tests_failed++;
      $display("FAIL lw_read_held: fetch=%0d memrd=%0d expected 4/4", n_fetch_rd, n_mem_rd);
    end
    tests_run++;
    if (act_ir != 1 || n_iord != 4) begin
      tests_failed++;
      $display("FAIL lw_ir_iord: ir_write=%0d i_or_d=%0d expected 1/4", act_ir, n_iord);
    end
    wb = at_state(S_MEM_WB);
    tests_run++;
    if ({wb.reg_write, wb.mem_to_reg, wb.reg_dst} !== 3'b110) begin
      tests_failed++;
      $display("FAIL lw_writeback: rw/m2r/dst=%b expected 110", {wb.reg_write, wb.mem_to_reg, wb.reg_dst});
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops [3];
    logic       zs  [3];
    int         ld  [3];
    obs_t br;
    ops = '{6'h04, 6'h05, 6'h05};
    zs  = '{1'b1, 1'b1, 1'b0};
    ld  = '{1, 0, 1};
    for (int k = 0; k < 3; k++) begin
      run_instr(ops[k], 6'h00, zs[k], 1'b0, 0, 0);
      tally();
      br = at_state(S_BRANCH);
      tests_run++;
      if (timed_out || act_pcc != ld[k] || br.pc_source !== 2'd1 || act_pcw != 1) begin
        tests_failed++;
        $display("FAIL branch_%0d: load=%0d pc_source=%0d pc_write=%0d expected %0d/1/1", k, act_pcc, br.pc_source, act_pcw, ld[k]);
      end
    end
  endtask

  task automatic test_rtype();
    obs_t ex, wb;
    run_instr(6'h00, 6'h20, 1'b0, 1'b0, 0, 0);
    ex = at_state(S_R_EXEC);
    wb = at_state(S_R_WB);
    tests_run++;
    if (timed_out || tr.size() != 4) begin
      tests_failed++;
      $display("FAIL rtype_cycles: got %0d expected 4", tr.size());
    end
    tests_run++;
    if (ex.alu_op !== 3'd7 || ex.alu_src_a !== 1'b1 || wb.reg_dst !== 1'b1 || wb.reg_write !== 1'b1) begin
      tests_failed++;
      $display("FAIL rtype_ctrl: alu_op=%0d src_a=%b reg_dst=%b reg_write=%b expected 7/1/1/1", ex.alu_op, ex.alu_src_a, wb.reg_dst, wb.reg_write);
    end
  endtask

  task automatic test_jump();
    obs_t jp;
    run_instr(6'h02, 6'h00, 1'b0, 1'b0, 1, 0);
    jp = at_state(S_JUMP);
    tests_run++;
    if (timed_out || jp.pc_source !== 2'd2 || jp.pc_write !== 1'b1) begin
      tests_failed++;
      $display("FAIL jump: pc_source=%0d pc_write=%b expected 2/1", jp.pc_source, jp.pc_write);
    end
  endtask

`ifdef CTRL_EXCEPTION_EN
  task automatic test_exception();
    obs_t ex;
    run_instr(6'h08, 6'h00, 1'b0, 1'b1, 0, 0);
    tally();
    ex = at_state(EXC_CODE);
    tests_run++;
    if (timed_out || act_rw != 0 || ex.epc_write !== 1'b1 || ex.exception !== 1'b1 ||
        ex.pc_source !== 2'd3 || ex.pc_write !== 1'b1 || act_excp != 1) begin
      tests_failed++;
      $display("FAIL addi_ovf_exc: reg_write=%0d epc=%b exc=%b pc_source=%0d pulses=%0d expected 0/1/1/3/1",
               act_rw, ex.epc_write, ex.exception, ex.pc_source, act_excp);
    end
    run_instr(6'h3F, 6'h00, 1'b0, 1'b0, 0, 0);
    build_expected(6'h3F, 6'h00, 1'b0, 1'b0, 0, 0);
    tests_run++;
    if (timed_out || path_mismatch() != -1) begin
      tests_failed++;
      $display("FAIL illegal_exc: cycles=%0d mismatch_at=%0d expected cycles=%0d", tr.size(), path_mismatch(), exp_q.size());
    end
  endtask
`else
  task automatic test_illegal_nop();
    run_instr(6'h3F, 6'h00, 1'b0, 1'b1, 0, 0);
    tally();
    tests_run++;
    if (timed_out || tr.size() != 2 || tr[1].st !== S_DECODE) begin
      tests_failed++;
      $display("FAIL illegal_nop_path: cycles=%0d expected 2 (FETCH,DECODE)", tr.size());
    end
    tests_run++;
    if (act_rw != 0 || act_wr != 0 || act_pcw != 1 || act_pcc != 0 || act_epc != 0 || act_excp != 0) begin
      tests_failed++;
      $display("FAIL illegal_nop_writes: rw=%0d mw=%0d pcw=%0d pcc=%0d epc=%0d exc=%0d expected 0/0/1/0/0/0",
               act_rw, act_wr, act_pcw, act_pcc, act_epc, act_excp);
    end
  endtask
`endif

  task automatic test_random();
    logic [5:0] pool   [8];
    logic [5:0] bad    [4];
    logic [5:0] fns    [5];
    logic [5:0] op, fn;
    logic z, ov;
    int fl, ml;
    pool = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h3F};
    bad  = '{6'h3F, 6'h01, 6'h10, 6'h2A};
    fns  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    for (int n = 0; n < 40; n++) begin
      op = pool[$urandom_range(0, 7)];
      if (op == 6'h3F) op = bad[$urandom_range(0, 3)];
      fn = fns[$urandom_range(0, 4)];
      z  = 1'($urandom_range(0, 1));
      ov = 1'($urandom_range(0, 1));
      fl = $urandom_range(0, 3);
      ml = $urandom_range(0, 3);
      run_instr(op, fn, z, ov, fl, ml);
      build_expected(op, fn, z, ov, fl, ml);
      tally();
      tests_run++;
      if (timed_out || path_mismatch() != -1) begin
        tests_failed++;
        $display("FAIL rnd%0d_path op=%h: cycles=%0d mismatch_at=%0d expected cycles=%0d", n, op, tr.size(), path_mismatch(), exp_q.size());
      end
      tests_run++;
      if (act_rd != exp_rd || act_wr != exp_wr || act_both != 0) begin
        tests_failed++;
        $display("FAIL rnd%0d_mem op=%h: rd=%0d wr=%0d both=%0d expected %0d/%0d/0", n, op, act_rd, act_wr, act_both, exp_rd, exp_wr);
      end
      tests_run++;
      if (act_ir != 1 || act_rw != exp_rw) begin
        tests_failed++;
        $display("FAIL rnd%0d_writes op=%h: ir=%0d rw=%0d expected 1/%0d", n, op, act_ir, act_rw, exp_rw);
      end
      tests_run++;
      if (act_pcw != exp_pcw || act_pcc != exp_pcc) begin
        tests_failed++;
        $display("FAIL rnd%0d_pc op=%h: pcw=%0d pcc=%0d expected %0d/%0d", n, op, act_pcw, act_pcc, exp_pcw, exp_pcc);
      end
      tests_run++;
      if (act_epc != exp_exc || act_excp != exp_exc) begin
        tests_failed++;
        $display("FAIL rnd%0d_exc op=%h: epc=%0d exc=%0d expected %0d/%0d", n, op, act_epc, act_excp, exp_exc, exp_exc);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_lw();
    test_branch();
    test_rtype();
    test_jump();
`ifdef CTRL_EXCEPTION_EN
    test_exception();
`else
    test_illegal_nop();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
